// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard control unit
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic {IDLE, WAIT} memfsm_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: selects the EX operand source, M result over W result over register file
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output fwd_sel_t   fwd
);
  always_comb
    fwd = (regwriteM && rsE == rdM && rsE != REG_ZERO) ? FWD_MEM :
          (regwriteW && rsE == rdW && rsE != REG_ZERO) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control with data-memory wait FSM and perf counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNTW        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rs1E,
  input  logic [4:0]      rs2E,
  input  logic [4:0]      rdE,
  input  logic [4:0]      rdM,
  input  logic [4:0]      rdW,
  input  logic            memrdE,
  input  logic            pcsrcE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memreqM,
  input  logic            memreadyM,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushD,
  output logic            flushE,
  output logic            flushW,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            memerr,
  output logic [CNTW-1:0] stallcyc,
  output logic [CNTW-1:0] flushcnt
);
  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);
  memfsm_t         state_q, state_d;
  logic [7:0]      waitcnt_q, waitcnt_d;
  logic            memerr_q, memerr_d;
  logic [CNTW-1:0] stallcyc_q, stallcyc_d, flushcnt_q, flushcnt_d;
  logic            lwstall, memstall, timeout;
  fwd_sel_t        fwd_a, fwd_b;
  forward_unit u_fwd_a (
    .rsE(rs1E), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .fwd(fwd_a)
  );
  forward_unit u_fwd_b (
    .rsE(rs2E), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW), .fwd(fwd_b)
  );
  assign forwardAE = fwd_a;
  assign forwardBE = fwd_b;
  assign memerr    = memerr_q;
  assign stallcyc  = stallcyc_q;
  assign flushcnt  = flushcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      waitcnt_q  <= '0;
      memerr_q   <= 1'b0;
      stallcyc_q <= '0;
      flushcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitcnt_q  <= waitcnt_d;
      memerr_q   <= memerr_d;
      stallcyc_q <= stallcyc_d;
      flushcnt_q <= flushcnt_d;
    end
  end
  always_comb begin
    timeout    = state_q == WAIT && waitcnt_q == TO;
    state_d    = state_q == IDLE ? ((memreqM && !memreadyM) ? WAIT : IDLE)
                                 : ((memreadyM || timeout) ? IDLE : WAIT);
    waitcnt_d  = state_d == WAIT ? waitcnt_q + 8'd1 : 8'd0;
    memerr_d   = memerr_q | (timeout & !memreadyM);
    stallcyc_d = (stallF && !(&stallcyc_q)) ? stallcyc_q + CNTW'(1) : stallcyc_q;
    flushcnt_d = (flushD && !(&flushcnt_q)) ? flushcnt_q + CNTW'(1) : flushcnt_q;
  end
  always_comb begin
    lwstall  = memrdE && rdE != REG_ZERO && (rdE == rs1D || rdE == rs2D);
    memstall = state_q == IDLE ? (memreqM && !memreadyM) : (!memreadyM && waitcnt_q != TO);
    stallF   = memstall | lwstall;
    stallD   = memstall | lwstall;
    stallE   = memstall;
    stallM   = memstall;
    flushW   = memstall;
    flushD   = pcsrcE & !memstall;
    flushE   = (lwstall | pcsrcE) & !memstall;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl against an independent cycle model
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic memrdE, pcsrcE, regwriteM, regwriteW, memreqM, memreadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, memerr;
  logic [1:0] forwardAE, forwardBE;
  logic [CW-1:0] stallcyc, flushcnt;
  always #5 clk = ~clk;
  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .rdM(rdM), .rdW(rdW), .memrdE(memrdE), .pcsrcE(pcsrcE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memreqM(memreqM), .memreadyM(memreadyM), .stallF(stallF),
    .stallD(stallD), .stallE(stallE), .stallM(stallM), .flushD(flushD), .flushE(flushE),
    .flushW(flushW), .forwardAE(forwardAE), .forwardBE(forwardBE), .memerr(memerr),
    .stallcyc(stallcyc), .flushcnt(flushcnt)
  );
  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, err;
    int sc, fc;
  } exp_t;
  exp_t sb_q[$];
  int total = 0, bad = 0;
  bit m_wait, m_err;
  int m_w, m_sc, m_fc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rm, input logic wm,
                                     input logic [4:0] rw, input logic ww);
    if (rs == 5'd0) return 2'b00;
    if (wm && rs == rm) return 2'b10;
    if (ww && rs == rw) return 2'b01;
    return 2'b00;
  endfunction
  task automatic clr();
    reset = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    memrdE = 0; pcsrcE = 0; regwriteM = 0; regwriteW = 0; memreqM = 0; memreadyM = 0;
  endtask
  task automatic step();
    exp_t e, o;
    bit lw, ms;
    lw = memrdE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    ms = m_wait ? (!memreadyM && m_w != TO) : (memreqM && !memreadyM);
    e.fa = fwd(rs1E, rdM, regwriteM, rdW, regwriteW);
    e.fb = fwd(rs2E, rdM, regwriteM, rdW, regwriteW);
    e.sf = ms || lw; e.sd = ms || lw; e.se = ms; e.sm = ms; e.fw = ms;
    e.fd = pcsrcE && !ms; e.fe = (lw || pcsrcE) && !ms;
    e.err = m_err; e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);
    #2;
    o = sb_q.pop_front();
    chk("fwdA", 32'(forwardAE), 32'(o.fa));
    chk("fwdB", 32'(forwardBE), 32'(o.fb));
    chk("stallF", 32'(stallF), 32'(o.sf));
    chk("stallD", 32'(stallD), 32'(o.sd));
    chk("stallE", 32'(stallE), 32'(o.se));
    chk("stallM", 32'(stallM), 32'(o.sm));
    chk("flushD", 32'(flushD), 32'(o.fd));
    chk("flushE", 32'(flushE), 32'(o.fe));
    chk("flushW", 32'(flushW), 32'(o.fw));
    chk("memerr", 32'(memerr), 32'(o.err));
    chk("stallcyc", 32'(stallcyc), o.sc);
    chk("flushcnt", 32'(flushcnt), o.fc);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_w = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (o.sf && m_sc < SAT) m_sc++;
      if (o.fd && m_fc < SAT) m_fc++;
      if (m_wait) begin
        if (memreadyM || m_w == TO) begin
          if (!memreadyM) m_err = 1;
          m_wait = 0; m_w = 0;
        end else m_w++;
      end else if (ms) begin
        m_wait = 1; m_w = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    bit lw;
    clr();
    reset = 1;
    m_wait = 0; m_w = 0; m_err = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    @(negedge clk);
    step();
    reset = 0;
    step();
    rdM = 5; regwriteM = 1; rs1E = 5; step();
    rdW = 5; regwriteW = 1; step();
    regwriteM = 0; rs2E = 5; step();
    rs1E = 0; rdM = 0; regwriteM = 1; rs2E = 0; step();
    clr();
    memrdE = 1; rdE = 7; rs2D = 7; step();
    clr(); step();
    memrdE = 1; rdE = 0; rs2D = 0; step();
    clr();
    pcsrcE = 1; step();
    clr(); step();
    memreqM = 1; steps(3);
    memreadyM = 1; step();
    memreadyM = 0; steps(2);
    memreadyM = 1; step();
    clr(); step();
    memreqM = 1; pcsrcE = 1; steps(2);
    memreadyM = 1; step();
    clr(); step();
    memreqM = 1; steps(7);
    clr(); steps(3);
    memreqM = 1; steps(2);
    reset = 1; memreqM = 0; step();
    reset = 0; steps(2);
    pcsrcE = 1; steps(SAT + 2);
    clr();
    memrdE = 1; rdE = 1; rs1D = 1; steps(SAT + 2);
    clr();
    reset = 1; step();
    reset = 0;
    for (int i = 0; i < 400; i++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
      memrdE = 1'($urandom_range(0, 1));
      lw = memrdE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      pcsrcE = !lw && ($urandom_range(0, 3) == 0);
      memreqM = $urandom_range(0, 3) != 0;
      memreadyM = $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 80) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
